shot_capture_ctrl: RTL and testbench

SHOT_CAPTURE_CTRL -- requirements
Module: shot_capture_ctrl

---
 rtl/shot_capture_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_shot_capture_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_capture_ctrl.sv
// ---------------------------------------------------------------------------
// shot_capture_ctrl
//   Captures one "shot" from a stream of accelerometer flick magnitudes.
//   Once armed, a sample at or above START_TH opens a shot. Samples at or
//   above RELEASE_TH are counted and peak-tracked. The first sample below
//   RELEASE_TH closes the shot. A shot with fewer than MIN_SAMPLES counted
//   samples is rejected as a glitch and the block re-arms. A valid shot is
//   presented on shot_valid/shot_peak/shot_dur until acknowledged. A fixed
//   COOLDOWN period then follows before the block returns to IDLE.
//
//   Optional feature macro: SHOT_TIMEOUT_EN
//     When this macro is defined, a shot that reaches TIMEOUT_SAMPLES counted
//     samples is abandoned, the block re-arms, and the sticky timeout flag is
//     set. When it is undefined, timeout is tied to 0 and the sample count
//     only saturates.
//
// Ports
//   clk          in   1   single clock (accelerometer domain)
//   rst_n        in   1   asynchronous active-low reset
//   arm          in   1   arm request, honoured only in IDLE
//   abort        in   1   synchronous return to IDLE, highest priority
//   flick_valid  in   1   flick sample strobe
//   flick        in  16   unsigned flick magnitude
//   shot_ack     in   1   consumer acknowledge, honoured only in DONE
//   shot_valid   out  1   result available
//   shot_peak    out 16   peak flick of the last valid shot
//   shot_dur     out 16   counted samples of the last valid shot
//   busy         out  1   state is not IDLE
//   state_dbg    out  3   state encoding
//   timeout      out  1   sticky timeout flag
//
//   state    | meaning
//   IDLE     | waiting for arm
//   ARMED    | waiting for a sample >= START_TH
//   TRACK    | shot in progress, counting and peak-tracking
//   DONE     | result presented, waiting for shot_ack
//   COOLDOWN | fixed dead time before IDLE
// ---------------------------------------------------------------------------
module shot_capture_ctrl #(
  parameter logic [15:0] START_TH        = 16'd400,
  parameter logic [15:0] RELEASE_TH      = 16'd150,
  parameter logic [15:0] MIN_SAMPLES     = 16'd4,
  parameter logic [23:0] COOLDOWN_CYC    = 24'd400000,
  parameter logic [15:0] TIMEOUT_SAMPLES = 16'd2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        abort,
  input  logic        flick_valid,
  input  logic [15:0] flick,
  input  logic        shot_ack,
  output logic        shot_valid,
  output logic [15:0] shot_peak,
  output logic [15:0] shot_dur,
  output logic        busy,
  output logic [2:0]  state_dbg,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    TRACK    = 3'd2,
    DONE     = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  // A zero cooldown still spends one cycle in COOLDOWN.
  localparam logic [23:0] CD_LOAD = (COOLDOWN_CYC == 24'd0) ? 24'd1 : COOLDOWN_CYC;

  state_t      state_q;
  logic [15:0] peak_q;
  logic [15:0] cnt_q;
  logic [23:0] cd_q;
  logic        shot_valid_q;
  logic [15:0] shot_peak_q;
  logic [15:0] shot_dur_q;
  logic        busy_q;

  logic [15:0] cnt_d;
  logic [15:0] peak_d;

  always_comb begin
    cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    peak_d = (flick > peak_q) ? flick : peak_q;
  end

`ifdef SHOT_TIMEOUT_EN
  logic timeout_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      peak_q       <= '0;
      cnt_q        <= '0;
      cd_q         <= '0;
      shot_valid_q <= 1'b0;
      shot_peak_q  <= '0;
      shot_dur_q   <= '0;
      busy_q       <= 1'b0;
`ifdef SHOT_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else if (abort) begin
      // Result registers are deliberately kept; only the handshake is dropped.
      state_q      <= IDLE;
      cnt_q        <= '0;
      cd_q         <= '0;
      shot_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SHOT_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q <= ARMED;
            busy_q  <= 1'b1;
`ifdef SHOT_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end

        ARMED: begin
          if (flick_valid && (flick >= START_TH)) begin
            state_q <= TRACK;
            peak_q  <= flick;
            cnt_q   <= 16'd1;
          end
        end

        TRACK: begin
          if (flick_valid) begin
            if (flick >= RELEASE_TH) begin
              cnt_q  <= cnt_d;
              peak_q <= peak_d;
`ifdef SHOT_TIMEOUT_EN
              if (cnt_d >= TIMEOUT_SAMPLES) begin
                state_q   <= ARMED;
                timeout_q <= 1'b1;
              end
`endif
            end else if (cnt_q >= MIN_SAMPLES) begin
              // Release sample itself is neither counted nor peak-compared.
              state_q      <= DONE;
              shot_peak_q  <= peak_q;
              shot_dur_q   <= cnt_q;
              shot_valid_q <= 1'b1;
            end else begin
              state_q <= ARMED;
            end
          end
        end

        DONE: begin
          if (shot_ack) begin
            state_q      <= COOLDOWN;
            shot_valid_q <= 1'b0;
            cd_q         <= CD_LOAD;
          end
        end

        COOLDOWN: begin
          if (cd_q <= 24'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cd_q    <= '0;
          end else begin
            cd_q <= cd_q - 24'd1;
          end
        end

        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          shot_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign shot_valid = shot_valid_q;
  assign shot_peak  = shot_peak_q;
  assign shot_dur   = shot_dur_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

`ifdef SHOT_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_shot_capture_ctrl.sv
module tb_shot_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        abort;
  logic        flick_valid;
  logic [15:0] flick;
  logic        shot_ack;
  logic        shot_valid;
  logic [15:0] shot_peak;
  logic [15:0] shot_dur;
  logic        busy;
  logic [2:0]  state_dbg;
  logic        timeout;

  int n_cmp;
  int n_bad;

  localparam int CD = 20;

  shot_capture_ctrl #(
    .START_TH(16'd400),
    .RELEASE_TH(16'd150),
    .MIN_SAMPLES(16'd4),
    .COOLDOWN_CYC(24'd20),
    .TIMEOUT_SAMPLES(16'd8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arm(arm),
    .abort(abort),
    .flick_valid(flick_valid),
    .flick(flick),
    .shot_ack(shot_ack),
    .shot_valid(shot_valid),
    .shot_peak(shot_peak),
    .shot_dur(shot_dur),
    .busy(busy),
    .state_dbg(state_dbg),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; outputs are observed on the next
  // falling edge, after the rising edge has consumed the inputs.
  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic sample(input logic [15:0] v);
    flick_valid = 1'b1;
    flick       = v;
    @(negedge clk);
    flick_valid = 1'b0;
    flick       = 16'd0;
  endtask

  task automatic ack_once();
    shot_ack = 1'b1;
    @(negedge clk);
    shot_ack = 1'b0;
  endtask

  // Counts cycles observed in COOLDOWN, starting with the current one.
  task automatic wait_cooldown(output int cycles);
    cycles = 0;
    while (state_dbg == 3'd4 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    arm = 1'b0; abort = 1'b0; flick_valid = 1'b0; flick = 16'd0; shot_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({shot_valid, shot_peak, shot_dur, busy, state_dbg, timeout} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%0b peak=%0d dur=%0d busy=%0b st=%0d to=%0b want all 0",
               shot_valid, shot_peak, shot_dur, busy, state_dbg, timeout);
    end
    rst_n = 1'b1;
    pulse_arm();
    n_cmp++;
    if (state_dbg !== 3'd1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL first_arm: got st=%0d busy=%0b want st=1 busy=1", state_dbg, busy);
    end
  endtask

  task automatic test_basic_shot();
    int cyc;
    sample(16'd500);
    n_cmp++;
    if (state_dbg !== 3'd2) begin
      n_bad++; $display("FAIL basic_track: got st=%0d want 2", state_dbg);
    end
    sample(16'd900);
    sample(16'd700);
    sample(16'd600);
    n_cmp++;
    if (shot_valid !== 1'b0 || state_dbg !== 3'd2) begin
      n_bad++; $display("FAIL basic_pre_release: got valid=%0b st=%0d want 0 / 2", shot_valid, state_dbg);
    end
    sample(16'd100);
    n_cmp++;
    if (state_dbg !== 3'd3 || shot_valid !== 1'b1 || shot_peak !== 16'd900 || shot_dur !== 16'd4) begin
      n_bad++;
      $display("FAIL basic_done: got st=%0d valid=%0b peak=%0d dur=%0d want 3 1 900 4",
               state_dbg, shot_valid, shot_peak, shot_dur);
    end
    ack_once();
    n_cmp++;
    if (shot_valid !== 1'b0 || state_dbg !== 3'd4 || busy !== 1'b1) begin
      n_bad++; $display("FAIL basic_ack: got valid=%0b st=%0d busy=%0b want 0 4 1", shot_valid, state_dbg, busy);
    end
    // arm and samples must be ignored while cooling down
    arm = 1'b1; flick_valid = 1'b1; flick = 16'd900;
    wait_cooldown(cyc);
    arm = 1'b0; flick_valid = 1'b0; flick = 16'd0;
    n_cmp++;
    if (cyc !== CD || state_dbg !== 3'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_cooldown: got cycles=%0d st=%0d busy=%0b want %0d 0 0", cyc, state_dbg, busy, CD);
    end
  endtask

  task automatic test_glitch_and_thresholds();
    pulse_arm();
    sample(16'd450);
    sample(16'd300);
    sample(16'd50);
    n_cmp++;
    if (state_dbg !== 3'd1 || shot_valid !== 1'b0 || shot_peak !== 16'd900 || shot_dur !== 16'd4) begin
      n_bad++;
      $display("FAIL glitch_reject: got st=%0d valid=%0b peak=%0d dur=%0d want 1 0 900 4",
               state_dbg, shot_valid, shot_peak, shot_dur);
    end
    sample(16'd399);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 3'd1) begin
      n_bad++; $display("FAIL below_start: got st=%0d want 1", state_dbg);
    end
    sample(16'd400);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 3'd2) begin
      n_bad++; $display("FAIL at_start: got st=%0d want 2", state_dbg);
    end
    sample(16'd150);
    sample(16'd150);
    sample(16'd150);
    sample(16'd149);
    n_cmp++;
    if (state_dbg !== 3'd3 || shot_valid !== 1'b1 || shot_peak !== 16'd400 || shot_dur !== 16'd4) begin
      n_bad++;
      $display("FAIL release_boundary: got st=%0d valid=%0b peak=%0d dur=%0d want 3 1 400 4",
               state_dbg, shot_valid, shot_peak, shot_dur);
    end
  endtask

  task automatic test_hold_ack();
    int bad_cycles;
    int cyc;
    bad_cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      arm         = i[0];
      flick_valid = i[1];
      flick       = 16'd2000;
      @(negedge clk);
      if (shot_valid !== 1'b1 || shot_peak !== 16'd400 || shot_dur !== 16'd4 || state_dbg !== 3'd3)
        bad_cycles++;
    end
    arm = 1'b0; flick_valid = 1'b0; flick = 16'd0;
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad_cycles);
    end
    ack_once();
    n_cmp++;
    if (shot_valid !== 1'b0 || state_dbg !== 3'd4) begin
      n_bad++; $display("FAIL hold_ack: got valid=%0b st=%0d want 0 4", shot_valid, state_dbg);
    end
    wait_cooldown(cyc);
    n_cmp++;
    if (cyc !== CD || state_dbg !== 3'd0) begin
      n_bad++; $display("FAIL hold_cooldown: got cycles=%0d st=%0d want %0d 0", cyc, state_dbg, CD);
    end
  endtask

  task automatic test_abort_ack();
    pulse_arm();
    repeat (4) sample(16'd1000);
    sample(16'd0);
    n_cmp++;
    if (state_dbg !== 3'd3 || shot_peak !== 16'd1000 || shot_dur !== 16'd4) begin
      n_bad++; $display("FAIL abort_setup: got st=%0d peak=%0d dur=%0d want 3 1000 4", state_dbg, shot_peak, shot_dur);
    end
    abort = 1'b1; shot_ack = 1'b1;
    @(negedge clk);
    abort = 1'b0; shot_ack = 1'b0;
    n_cmp++;
    if (state_dbg !== 3'd0 || shot_valid !== 1'b0 || busy !== 1'b0 || shot_peak !== 16'd1000 || shot_dur !== 16'd4) begin
      n_bad++;
      $display("FAIL abort_ack: got st=%0d valid=%0b busy=%0b peak=%0d dur=%0d want 0 0 0 1000 4",
               state_dbg, shot_valid, busy, shot_peak, shot_dur);
    end
    abort = 1'b1; arm = 1'b1;
    @(negedge clk);
    abort = 1'b0; arm = 1'b0;
    n_cmp++;
    if (state_dbg !== 3'd0) begin
      n_bad++; $display("FAIL abort_over_arm: got st=%0d want 0", state_dbg);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    logic        exp_to;
    logic [2:0]  exp_st8;
    logic [15:0] exp_dur;
`ifdef SHOT_TIMEOUT_EN
    exp_to = 1'b1; exp_st8 = 3'd1; exp_dur = 16'd4;
`else
    exp_to = 1'b0; exp_st8 = 3'd2; exp_dur = 16'd10;
`endif
    pulse_arm();
    repeat (8) sample(16'd800);
    n_cmp++;
    if (state_dbg !== exp_st8 || timeout !== exp_to) begin
      n_bad++; $display("FAIL timeout_8th: got st=%0d to=%0b want %0d %0b", state_dbg, timeout, exp_st8, exp_to);
    end
    repeat (2) sample(16'd800);
`ifdef SHOT_TIMEOUT_EN
    repeat (2) sample(16'd800);
`endif
    sample(16'd100);
    n_cmp++;
    if (state_dbg !== 3'd3 || shot_peak !== 16'd800 || shot_dur !== exp_dur) begin
      n_bad++; $display("FAIL timeout_shot: got st=%0d peak=%0d dur=%0d want 3 800 %0d", state_dbg, shot_peak, shot_dur, exp_dur);
    end
    ack_once();
    wait_cooldown(cyc);
    n_cmp++;
    if (state_dbg !== 3'd0 || timeout !== exp_to) begin
      n_bad++; $display("FAIL timeout_sticky: got st=%0d to=%0b want 0 %0b", state_dbg, timeout, exp_to);
    end
    pulse_arm();
    n_cmp++;
    if (state_dbg !== 3'd1 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_clear: got st=%0d to=%0b want 1 0", state_dbg, timeout);
    end
  endtask

  task automatic test_reset_mid();
    int seen_valid;
    sample(16'd500);
    sample(16'd600);
    n_cmp++;
    if (state_dbg !== 3'd2) begin
      n_bad++; $display("FAIL resetmid_setup: got st=%0d want 2", state_dbg);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({shot_valid, shot_peak, shot_dur, busy, state_dbg, timeout} !== 37'd0) begin
      n_bad++;
      $display("FAIL resetmid_async: got valid=%0b peak=%0d dur=%0d busy=%0b st=%0d to=%0b want all 0",
               shot_valid, shot_peak, shot_dur, busy, state_dbg, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    sample(16'd100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (shot_valid !== 1'b0 || state_dbg !== 3'd0) seen_valid++;
    end
    n_cmp++;
    if (seen_valid !== 0) begin
      n_bad++; $display("FAIL resetmid_no_valid: got %0d bad cycles want 0", seen_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic_shot();
    test_glitch_and_thresholds();
    test_hold_ack();
    test_abort_ack();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
